// File: rtl/shift_issue_stage.sv
// Decode/issue stage for the RV32I shift instructions, with a two-entry skid buffer
// in front of the Shift_Unit. Buffer states: EMPTY = no entry, ONE = head only, FULL = head + skid.
module shift_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            Flush,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [31:0]     Instr,
  input  logic [XLEN-1:0] Rs1_Data,
  input  logic [XLEN-1:0] Rs2_Data,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [XLEN-1:0] Src1,
  output logic [4:0]      Src2,
  output logic            funct3_2,
  output logic            funct7_5,
  output logic            En,
  output logic            Illegal,
  output logic [4:0]      Rd
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] src1;
    logic [4:0]      src2;
    logic            f3_2;
    logic            f7_5;
    logic            en;
    logic            illegal;
    logic [4:0]      rd;
  } entry_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op;
  logic       is_op_imm;
  logic       is_shift;
  logic       funct7_ok;
  entry_t     in_entry;
  logic       push;
  logic       pop;

  // Fields not needed by the shifter are deliberately dropped.
  logic unused_bits;
  assign unused_bits = ^{Instr[19:15], Rs2_Data[XLEN-1:5]};

  always_comb begin
    opcode    = Instr[6:0];
    funct3    = Instr[14:12];
    funct7    = Instr[31:25];
    is_op     = (opcode == OPC_OP);
    is_op_imm = (opcode == OPC_OP_IMM);
    is_shift  = (is_op || is_op_imm) && ((funct3 == 3'b001) || (funct3 == 3'b101));
    // Only right shifts may carry the arithmetic bit; anything else in funct7 is illegal.
    funct7_ok = (funct7 == 7'b0000000) ||
                ((funct3 == 3'b101) && (funct7 == 7'b0100000));

    in_entry         = '0;
    in_entry.src1    = Rs1_Data;
    in_entry.src2    = is_op ? Rs2_Data[4:0] : Instr[24:20];
    in_entry.f3_2    = Instr[14];
    in_entry.f7_5    = Instr[30];
    in_entry.en      = is_shift && funct7_ok;
    in_entry.illegal = is_shift && !funct7_ok;
    in_entry.rd      = Instr[11:7];
  end

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    skid_d    = skid_q;
    In_Ready  = (state_q != ST_FULL);
    Out_Valid = (state_q != ST_EMPTY);
    push      = In_Valid && In_Ready;
    pop       = Out_Valid && Out_Ready;

    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          skid_d  = in_entry;
          state_d = ST_FULL;
        end else if (push && pop) begin
          head_d  = in_entry;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (Flush) begin
      head_d  = head_q;
      skid_d  = skid_q;
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign Src1     = head_q.src1;
  assign Src2     = head_q.src2;
  assign funct3_2 = head_q.f3_2;
  assign funct7_5 = head_q.f7_5;
  assign En       = head_q.en;
  assign Illegal  = head_q.illegal;
  assign Rd       = head_q.rd;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage: directed instructions with hand-decoded expectations.
module tb_shift_issue_stage;

  typedef logic [45:0] ent_t;

  logic        CLK = 1'b0;
  logic        rst;
  logic        Flush;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] Instr;
  logic [31:0] Rs1_Data;
  logic [31:0] Rs2_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Src1;
  logic [4:0]  Src2;
  logic        funct3_2;
  logic        funct7_5;
  logic        En;
  logic        Illegal;
  logic [4:0]  Rd;

  ent_t exp_q[$];
  ent_t exp_cur;
  ent_t dut_ent;
  ent_t prev_ent;
  logic prev_stall = 1'b0;
  int   errors = 0;
  int   checks = 0;

  shift_issue_stage #(.XLEN(32)) dut (
    .CLK(CLK), .rst(rst), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Instr(Instr), .Rs1_Data(Rs1_Data), .Rs2_Data(Rs2_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Src1(Src1), .Src2(Src2), .funct3_2(funct3_2), .funct7_5(funct7_5),
    .En(En), .Illegal(Illegal), .Rd(Rd)
  );

  always #5 CLK = ~CLK;

  assign dut_ent = {Src1, Src2, funct3_2, funct7_5, En, Illegal, Rd};

  function automatic ent_t mk(logic [31:0] s1, logic [4:0] s2, logic f3, logic f7,
                              logic en, logic il, logic [4:0] rd);
    return {s1, s2, f3, f7, en, il, rd};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: compares popped entries, checks hold-stability, then records new pushes.
  always @(negedge CLK) begin
    if (prev_stall && (Out_Valid === 1'b1))
      check("hold_stable", dut_ent, prev_ent);
    if ((Out_Valid === 1'b1) && (Out_Ready === 1'b1)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h required no output", dut_ent);
      end else begin
        check("scoreboard", dut_ent, exp_q.pop_front());
      end
    end
    prev_stall = (Out_Valid === 1'b1) && (Out_Ready === 1'b0);
    prev_ent   = dut_ent;
    if (rst || Flush)
      exp_q.delete();
    else if ((In_Valid === 1'b1) && (In_Ready === 1'b1))
      exp_q.push_back(exp_cur);
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic present(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2, ent_t e);
    Instr    = ins;
    Rs1_Data = r1;
    Rs2_Data = r2;
    exp_cur  = e;
    In_Valid = 1'b1;
  endtask

  task automatic send(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2, ent_t e);
    logic done;
    done = 1'b0;
    present(ins, r1, r2, e);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      if (In_Ready === 1'b1) done = 1'b1;
      tick();
    end
    In_Valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got In_Ready=0 for 50 cycles required acceptance");
    end
  endtask

  initial begin
    rst = 1'b1; Flush = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b1;
    Instr = '0; Rs1_Data = '0; Rs2_Data = '0; exp_cur = '0;
    repeat (2) tick();
    check("reset_out_valid", Out_Valid, 0);
    check("reset_in_ready", In_Ready, 1);
    check("reset_outputs", dut_ent, 0);
    rst = 1'b0;
    tick();

    // SLLI x5,x1,3 then one-cycle latency
    send(32'h00309293, 32'h0000_00F0, 32'h0, mk(32'h0000_00F0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5));
    check("latency_out_valid", Out_Valid, 1);
    tick();

    // Back-to-back stream of decode cases
    send(32'h4020D1B3, 32'h8000_0000, 32'hFFFF_FFE4, mk(32'h8000_0000, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3));
    send(32'h0220D093, 32'h1234_5678, 32'h0, mk(32'h1234_5678, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1));
    send(32'h002081B3, 32'h0000_0777, 32'h2, mk(32'h0000_0777, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3));
    send(32'h4030D093, 32'hF000_000F, 32'h0, mk(32'hF000_000F, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1));
    send(32'h402091B3, 32'h0000_0055, 32'h1F, mk(32'h0000_0055, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3));
    send(32'h00108093, 32'h0000_0066, 32'h1, mk(32'h0000_0066, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1));
    repeat (2) tick();

    // Backpressure: two accepted, third stalls, then drain in order
    Out_Ready = 1'b0;
    present(32'h0220D093, 32'h0000_000A, 32'h0, mk(32'h0000_000A, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1));
    tick();
    present(32'h402091B3, 32'h0000_000B, 32'h1F, mk(32'h0000_000B, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3));
    tick();
    present(32'h4030D093, 32'h0000_000C, 32'h0, mk(32'h0000_000C, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1));
    check("full_in_ready", In_Ready, 0);
    check("full_out_valid", Out_Valid, 1);
    repeat (2) tick();
    check("stall_depth", exp_q.size(), 2);
    Out_Ready = 1'b1;
    send(32'h4030D093, 32'h0000_000C, 32'h0, mk(32'h0000_000C, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1));
    repeat (3) tick();

    // Flush while FULL with a presented instruction
    Out_Ready = 1'b0;
    present(32'h00309293, 32'h0000_0011, 32'h0, mk(32'h0000_0011, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5));
    tick();
    present(32'h4020D1B3, 32'h0000_0022, 32'h7, mk(32'h0000_0022, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3));
    tick();
    present(32'h4030D093, 32'h0000_0033, 32'h0, mk(32'h0000_0033, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1));
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    In_Valid = 1'b0;
    check("flush_out_valid", Out_Valid, 0);
    check("flush_in_ready", In_Ready, 1);
    Out_Ready = 1'b1;
    repeat (3) tick();
    send(32'h002081B3, 32'h0000_0044, 32'h2, mk(32'h0000_0044, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3));
    repeat (2) tick();

    // Reset mid-stream while FULL
    Out_Ready = 1'b0;
    present(32'h00309293, 32'h0000_0099, 32'h0, mk(32'h0000_0099, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5));
    tick();
    present(32'h4020D1B3, 32'h0000_00AA, 32'h3, mk(32'h0000_00AA, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3));
    tick();
    present(32'h0220D093, 32'h0000_00BB, 32'h0, mk(32'h0000_00BB, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    In_Valid = 1'b0;
    check("rst_out_valid", Out_Valid, 0);
    check("rst_in_ready", In_Ready, 1);
    check("rst_outputs", dut_ent, 0);
    Out_Ready = 1'b1;
    repeat (3) tick();
    send(32'h4030D093, 32'h0000_00CC, 32'h0, mk(32'h0000_00CC, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1));
    repeat (3) tick();

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got simulation still running required finish");
    $fatal(1, "timeout");
  end

endmodule
